// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared constants and types for the memory-port arbiter slice:
//   default address/data widths, requester-ID width and the FSM state
//   encoding (ST_CLEAR is only used when MEM_PORT_ARBITER_CLEAR_EN is defined).
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_AW = 3;
  localparam int unsigned DEF_DW = 8;
  localparam int unsigned RID_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. Searches upward from the
//   pointer index (modulo NREQ) and grants the first active request.
// Ports:
//   req_i  per-requester request
//   ptr_i  priority pointer (index searched first)
//   en_i   grant enable; 0 forces no grant
//   gnt_o  one-hot grant
//   idx_o  encoded index of the winner (0 when no grant)
module rr_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [RID_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [RID_W-1:0] idx_o
);

  logic found;

  // Two passes: first indices at or above the pointer, then wrap to the
  // lowest active index. Equivalent to a modulo-NREQ search from ptr_i.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (en_i && !found && req_i[i] && (i >= int'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        idx_o    = RID_W'(i);
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (en_i && !found && req_i[i]) begin
        gnt_o[i] = 1'b1;
        idx_o    = RID_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a 2^AW x DW register-file memory among NREQ requesters with a
//   round-robin policy, one read or write per cycle. Reads return on a
//   registered bus tagged with the requester ID, one cycle after the grant.
//   Optional memory-clear sweep enabled by defining MEM_PORT_ARBITER_CLEAR_EN.
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-low reset
//   req     per-requester request (level)
//   we      per-requester write enable (0 = read)
//   addr    packed addresses, requester i at [i*AW +: AW]
//   wdata   packed write data, requester i at [i*DW +: DW]
//   clr     one-cycle memory-clear command
//   gnt     one-hot combinational grant
//   rvalid  read data valid pulse
//   rid     requester ID of completed read
//   rdata   read data (holds when rvalid=0)
//   busy    clear sweep in progress
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = DEF_AW,
  parameter int unsigned DW   = DEF_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  input  logic                 clr,
  output logic [NREQ-1:0]      gnt,
  output logic                 rvalid,
  output logic [RID_W-1:0]     rid,
  output logic [DW-1:0]        rdata,
  output logic                 busy
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0]    mem_q [DEPTH];

  logic             arb_en;
  logic [NREQ-1:0]  arb_gnt;
  logic [RID_W-1:0] win_idx;
  logic             any_gnt;

  logic [RID_W-1:0] ptr_q, ptr_d;

  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [DW-1:0]    mem_wdata;

  logic             rvalid_q, rvalid_d;
  logic [RID_W-1:0] rid_q, rid_d;
  logic [DW-1:0]    rdata_q, rdata_d;

`ifdef MEM_PORT_ARBITER_CLEAR_EN
  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;

  // clr wins over any request in the same cycle; reset also blocks grants.
  assign arb_en = rst && (state_q == ST_IDLE) && !clr;
  assign busy   = (state_q == ST_CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign arb_en     = rst;
  assign busy       = 1'b0;
`endif

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i (req),
    .ptr_i (ptr_q),
    .en_i  (arb_en),
    .gnt_o (arb_gnt),
    .idx_o (win_idx)
  );

  assign any_gnt = |arb_gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      if (win_idx == RID_W'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx + RID_W'(1);
      end
    end
  end

  always_comb begin
    mem_we    = any_gnt && sel_we;
    mem_waddr = sel_addr;
    mem_wdata = sel_wdata;
`ifdef MEM_PORT_ARBITER_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end
`endif
  end

  always_comb begin
    rvalid_d = any_gnt && !sel_we;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    if (rvalid_d) begin
      rid_d   = win_idx;
      rdata_d = mem_q[sel_addr];
    end
  end

  // Memory contents survive reset; the arbiter enable and FSM reset keep it
  // from being written while rst is low.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign gnt    = arb_gnt;
  assign rvalid = rvalid_q;
  assign rid    = rid_q;
  assign rdata  = rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Controller that shares the 8-entry × 8-bit register-file memory among several requesters (key/switch write front-end, display scanner, etc.). It arbitrates per-cycle access with a round-robin policy and performs at most one read or write per cycle. Read data is returned on a common registered bus tagged with the requester ID. It owns the memory array and sits between the input-debounce/edge-detect logic and the LED/7-segment output logic.

## Interface
Parameters:
- NREQ, 2, number of requesters (2..4)
- AW, 3, address width (memory depth 2^AW)
- DW, 8, data width

Ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester access request (level, held until granted)
- we  in  NREQ  per-requester write enable; 0 = read
- addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- wdata  in  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW]
- clr  in  1  one-cycle memory-clear command (see Configuration)
- gnt  out  NREQ  one-hot grant; combinational, valid in the cycle the access is taken
- rvalid  out  1  read data valid (registered)
- rid  out  2  ID of the requester whose read completed
- rdata  out  DW  read data
- busy  out  1  clear sweep in progress; no grants are issued

## Operation
- Reset (rst=0) forces: gnt=0, rvalid=0, rid=0, rdata=0, busy=0, priority pointer=0, FSM=IDLE, sweep counter=0. Memory contents are not reset.
- FSM states: IDLE and CLEAR. CLEAR exists only with the macro defined.
- IDLE: if any req is asserted, the arbiter grants exactly one requester. The search starts at the pointer index and proceeds upward modulo NREQ. gnt[i] is high only for that requester.
- Granted write (we[i]=1): memory[addr_i] <= wdata_i at the clock edge.
- Granted read (we[i]=0): rdata <= memory[addr_i], rid <= i, rvalid <= 1 at the same edge.
- rvalid is a one-cycle pulse. It is 0 in any cycle following a cycle with no granted read. rdata holds its last value when rvalid=0.
- After any grant to requester i, the pointer becomes (i+1) mod NREQ. The pointer is unchanged when there is no grant.
- Requesters keep req, we, addr and wdata stable until they sample gnt[i]=1 at an edge. They drop req, or present the next request, in the following cycle.
- A requester that holds req continuously with other requesters active is granted at least once every NREQ cycles.
- req bits at indices ≥ NREQ do not exist. An out-of-range pointer is impossible by construction.

## Timing
- Grant latency: 0 cycles. gnt is combinational from req, pointer and FSM state in the same cycle.
- Write latency: data is stored at the granting edge. A read of the same address granted in the next cycle returns the new value.
- Read latency: 1 cycle. rvalid, rid and rdata are valid in the cycle after gnt.
- Throughput: one access per cycle, including back-to-back accesses by the same requester when it is the only one requesting.
- clr in the same cycle as req: clr wins. No grant is issued in that cycle and the pointer is unchanged.

## Configuration
- Macro: MEM_PORT_ARBITER_CLEAR_EN.
- Defined:
  - clr=1 in IDLE moves the FSM to CLEAR at the next edge with counter=0.
  - In CLEAR, memory[counter] <= 0 each cycle and counter increments. The FSM returns to IDLE after writing address 2^AW−1, so the sweep takes 2^AW cycles.
  - busy=1 and gnt=0 throughout CLEAR. clr is ignored while in CLEAR.
  - Reset during CLEAR aborts the sweep. Already-cleared entries stay 0; the rest keep their old values.
- Not defined: clr is ignored, busy is tied to 0, no CLEAR state or counter exists, and grants are never blocked.

## Structure
- Shared package holds: default AW/DW constants, the FSM state encoding (ST_IDLE, ST_CLEAR) and the requester-ID width constant.
- One sub-module, rr_arbiter. Inputs: req, pointer, enable. Outputs: one-hot gnt and the encoded winner index. This sub-module is purely combinational.
- Pointer, FSM, sweep counter, memory array and read register live in mem_port_arbiter.

## Test plan
- Reset release, then requester 0 writes 0x5A to address 3, then requester 1 reads address 3 → gnt[1] is high in the read cycle, and the next cycle shows rvalid=1, rid=1, rdata=0x5A.
- req=2'b11 held for 6 cycles with reads → gnt alternates 01,10,01,10,01,10 and rid alternates 0,1,0,1,0,1 one cycle later.
- Requester 0 writes 0x11 to address 7; in the next cycle requester 1 reads address 7 → rdata=0x11.
- With MEM_PORT_ARBITER_CLEAR_EN, fill all 8 addresses with 0xFF, then pulse clr together with req[0] → no grant that cycle, busy=1 for 8 cycles, all 8 reads afterwards return 0x00.
- With the macro, assert rst=0 during cycle 4 of the sweep, then release → addresses 0–3 read 0x00 and addresses 4–7 read 0xFF; busy=0 and the pointer is 0 after reset.
- Without the macro, pulse clr → busy stays 0, grants continue uninterrupted, memory is unchanged.
